// File: rtl/fpu_pkg.sv
// Shared types and sizing helpers for the operand loader.
package fpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  // Byte counter width. It covers operands up to 2048 bits.
  localparam int BYTE_CNT_W = 8;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/operand_reg.sv
// One operand register. It loads on en and clears on a synchronous active-low reset.
module operand_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rstn)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/operand_loader.sv
// Assembles LSB-first byte streams into per-channel operand registers.
//   state | meaning
//   IDLE  | waiting for the first byte; in_ready gated by target op_valid
//   LOAD  | partial operand in staging; every offered byte is accepted
module operand_loader
  import fpu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
) (
  input  logic                                             clk,
  input  logic                                             rstn,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [7:0]                                       in_data,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] in_ch,
  input  logic                                             in_abort,
  input  logic [CHANNELS-1:0]                              op_take,
  output logic [CHANNELS*WIDTH-1:0]                        op_data,
  output logic [CHANNELS-1:0]                              op_valid,
  output logic                                             busy
);

  localparam int BYTES = bytes_of(WIDTH);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_e                  state_q, state_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d, idx;
  logic [WIDTH-1:0]        stage_q, stage_d, stage_nxt;
  logic [CH_W-1:0]         ch_q, ch_d, ch_sel;
  logic [CHANNELS-1:0]     valid_q, valid_d, reg_en;
  logic [(2**CH_W)-1:0]    valid_pad;
  logic                    ch_ok, xfer, complete;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    stage_d    = stage_q;
    ch_d       = ch_q;
    complete   = 1'b0;
    reg_en     = '0;
    valid_pad  = '0;
    valid_pad[CHANNELS-1:0] = valid_q;

    ch_ok    = int'(in_ch) < CHANNELS;
    idx      = (state_q == LOAD) ? byte_cnt_q : '0;
    ch_sel   = (state_q == LOAD) ? ch_q : in_ch;
    in_ready = (state_q == LOAD) ? 1'b1 : (ch_ok && !valid_pad[in_ch]);
    xfer     = in_valid && in_ready;

    // Staging with the offered byte merged in. This lets completion load the full word on the same edge.
    stage_nxt = stage_q;
    stage_nxt[int'(idx)*8 +: 8] = in_data;

    if (in_abort) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
    end else if (xfer) begin
      stage_d = stage_nxt;
      if (idx == BYTE_CNT_W'(BYTES - 1)) begin
        complete   = 1'b1;
        state_d    = IDLE;
        byte_cnt_d = '0;
      end else begin
        state_d    = LOAD;
        byte_cnt_d = idx + 1'b1;
        if (state_q == IDLE) ch_d = in_ch;
      end
    end

    // Completion beats a simultaneous take on the same channel.
    for (int k = 0; k < CHANNELS; k++) begin
      reg_en[k]  = complete && (int'(ch_sel) == k);
      valid_d[k] = reg_en[k] | (valid_q[k] & ~op_take[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      stage_q    <= '0;
      ch_q       <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      stage_q    <= stage_d;
      ch_q       <= ch_d;
      valid_q    <= valid_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_reg
    operand_reg #(.WIDTH(WIDTH)) u_reg (
      .clk  (clk),
      .rstn (rstn),
      .en   (reg_en[g]),
      .d    (stage_nxt),
      .q    (op_data[g*WIDTH +: WIDTH])
    );
  end

  assign op_valid = valid_q;
  assign busy     = (state_q == LOAD);

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader at WIDTH=32, CHANNELS=2.
module tb_operand_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [0:0]  in_ch;
  logic        in_abort;
  logic [1:0]  op_take;
  logic [63:0] op_data;
  logic [1:0]  op_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  operand_loader #(.WIDTH(32), .CHANNELS(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ch    (in_ch),
    .in_abort (in_abort),
    .op_take  (op_take),
    .op_data  (op_data),
    .op_valid (op_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, cross an edge, then return to quiet inputs.
  task automatic drive(input logic v, input logic [7:0] b, input logic ch,
                       input logic ab, input logic [1:0] tk);
    in_valid = v; in_data = b; in_ch = ch; in_abort = ab; op_take = tk;
    tick();
    in_valid = 1'b0; in_abort = 1'b0; op_take = 2'b00;
  endtask

  task automatic load32(input logic [31:0] w, input logic ch);
    for (int i = 0; i < 4; i++) drive(1'b1, w[i*8 +: 8], ch, 1'b0, 2'b00);
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_ch = 1'b0;
    in_abort = 1'b0; op_take = 2'b00;
    tick(); tick();
    chk("rst_valid", {62'd0, op_valid}, 64'd0);
    chk("rst_data", op_data, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rstn = 1'b1;
    #1 chk("rst_ready", {63'd0, in_ready}, 64'd1);

    // Basic 4-byte load to ch0.
    drive(1'b1, 8'h78, 1'b0, 1'b0, 2'b00);
    chk("l0_busy", {63'd0, busy}, 64'd1);
    chk("l0_ready_load", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 8'h56, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 8'h34, 1'b0, 1'b0, 2'b00);
    chk("l0_valid_pre", {62'd0, op_valid}, 64'd0);
    drive(1'b1, 8'h12, 1'b0, 1'b0, 2'b00);
    chk("l0_valid", {62'd0, op_valid}, 64'd1);
    chk("l0_data", {32'd0, op_data[31:0]}, 64'h12345678);
    chk("l0_busy_end", {63'd0, busy}, 64'd0);

    // Backpressure on a full channel.
    load32(32'h11223344, 1'b1);
    chk("l1_valid", {62'd0, op_valid}, 64'd3);
    in_ch = 1'b0;
    #1 chk("ch0_full_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1; in_data = 8'h99; in_ch = 1'b1;
    #1 chk("ch1_full_ready", {63'd0, in_ready}, 64'd0);
    tick();
    in_valid = 1'b0;
    chk("blocked_busy", {63'd0, busy}, 64'd0);
    chk("blocked_data", op_data, 64'h11223344_12345678);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 2'b10);
    chk("take1_valid", {62'd0, op_valid}, 64'd1);
    chk("take1_hold", {32'd0, op_data[63:32]}, 64'h11223344);
    in_ch = 1'b1;
    #1 chk("ch1_free_ready", {63'd0, in_ready}, 64'd1);
    load32(32'h0A0B0C0D, 1'b1);
    chk("reoffer_data", op_data, 64'h0A0B0C0D_12345678);

    // Abort mid-operand, then a clean load.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b01);
    drive(1'b1, 8'h01, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 8'h02, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 8'h03, 1'b0, 1'b1, 2'b00);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_valid", {62'd0, op_valid}, 64'd2);
    load32(32'hAABBCCDD, 1'b0);
    chk("post_abort_data", {32'd0, op_data[31:0]}, 64'hAABBCCDD);
    chk("post_abort_valid", {62'd0, op_valid}, 64'd3);

    // Abort coinciding with the last byte wins.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b01);
    drive(1'b1, 8'hE1, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 8'hE2, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 8'hE3, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 8'hE4, 1'b0, 1'b1, 2'b00);
    chk("abort_last_valid", {62'd0, op_valid}, 64'd2);
    chk("abort_last_data", {32'd0, op_data[31:0]}, 64'hAABBCCDD);
    chk("abort_last_busy", {63'd0, busy}, 64'd0);

    // Completion and take on ch0 in the same cycle.
    drive(1'b1, 8'h0C, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 8'h0D, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 8'h0E, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 8'h0F, 1'b0, 1'b0, 2'b01);
    chk("take_vs_done_valid", {62'd0, op_valid}, 64'd3);
    chk("take_vs_done_data", {32'd0, op_data[31:0]}, 64'h0F0E0D0C);

    // Reset after three bytes.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b11);
    drive(1'b1, 8'h21, 1'b1, 1'b0, 2'b00);
    drive(1'b1, 8'h22, 1'b1, 1'b0, 2'b00);
    drive(1'b1, 8'h23, 1'b1, 1'b0, 2'b00);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("midrst_valid", {62'd0, op_valid}, 64'd0);
    chk("midrst_data", op_data, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    load32(32'h44332211, 1'b0);
    chk("postrst_data", op_data, 64'h00000000_44332211);
    chk("postrst_valid", {62'd0, op_valid}, 64'd1);

    // Gapped load to ch1 with in_ch toggled after the first byte.
    begin
      logic [31:0] w;
      w = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, w[i*8 +: 8], (i == 0) ? 1'b1 : 1'b0, 1'b0, 2'b00);
        if (i < 3) begin
          int gap;
          gap = int'($urandom_range(1, 3));
          for (int j = 0; j < gap; j++) drive(1'b0, 8'hFF, 1'b0, 1'b0, 2'b00);
          if (i == 1) chk("gap_busy", {63'd0, busy}, 64'd1);
        end
      end
    end
    chk("gap_data", op_data, 64'hDEADBEEF_44332211);
    chk("gap_valid", {62'd0, op_valid}, 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
